wb_bram_ctrl: RTL and testbench

Wishbone B4 classic slave that acts as the initiator on a single-port, byte-writable, synchronous-read block RAM port. It decodes a fixed address window, inserts a programmable access delay that models external-memory latency, drives exactly one BRAM enable cycle per transfer, and returns read data with a single-cycle ack. It sits between the SoC user-project Wishbone bus and the on-chip BRAM used as emulated execution memory for firmware and FIR data.

---
 rtl/wb_bram_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_wb_bram_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// wb_bram_ctrl
//
// Wishbone B4 classic slave that forwards single transfers inside a fixed
// address window to a single-port, byte-writable, synchronous-read BRAM.
// A programmable number of wait cycles is inserted before the BRAM access to
// emulate external-memory latency. Exactly one BRAM enable cycle is issued
// per accepted transfer, and the response is a single-cycle ack.
//
// Parameters:
//   N         - BRAM word-address width (window = 4*2^N bytes)
//   DELAYS    - wait cycles before the BRAM access (0..255)
//   BASE_ADDR - window base, aligned to 4*2^N
//
// Ports:
//   wb_clk_i, wb_rst_i      - clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    - Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i,
//   wbs_dat_i               - byte lanes, byte address, write data
//   wbs_ack_o, wbs_dat_o    - acknowledge and read data (0 when no ack)
//   bram_en, bram_we,
//   bram_a, bram_di         - BRAM enable, byte write enables, address, data
//   bram_do                 - BRAM read data (one cycle after bram_en)
//
// Optional feature macro: WB_BRAM_CTRL_POSTED_WRITE_EN
//   When defined, writes go straight from IDLE to ACCESS and are acked in
//   the ACCESS cycle itself; reads keep the full delayed path.
// -----------------------------------------------------------------------------
module wb_bram_ctrl #(
  parameter int          N         = 14,
  parameter int          DELAYS    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [N-1:0]  bram_a,
  output logic [31:0]   bram_di,
  input  logic [31:0]   bram_do
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [7:0] C_LAST = (DELAYS == 0) ? 8'd0 : 8'(DELAYS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_cnt;
  logic [N-1:0]  r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic          r_bram_en;
  logic [3:0]    r_bram_we;
  logic          r_ack_arm;
  logic          r_rd_resp;

  logic          w_req;
  logic          w_capture;
  logic          w_skip_wait;
  logic          w_we_nxt;
  logic [3:0]    w_sel_nxt;
  logic          w_ack_nxt;
  logic          w_unused;

  // Byte-offset bits never take part in the decode.
  assign w_unused  = ^wbs_adr_i[1:0];

  assign w_req     = wbs_cyc_i & wbs_stb_i &
                     (wbs_adr_i[31:N+2] == BASE_ADDR[31:N+2]);
  assign w_capture = (r_state == S_IDLE) & w_req;

  // Values the latch registers will hold after this edge; used so the
  // registered BRAM strobes line up with the ACCESS state.
  assign w_we_nxt  = w_capture ? wbs_we_i  : r_we;
  assign w_sel_nxt = w_capture ? wbs_sel_i : r_sel;

`ifdef WB_BRAM_CTRL_POSTED_WRITE_EN
  assign w_skip_wait = (DELAYS == 0) | wbs_we_i;
  assign w_ack_nxt   = (w_state_nxt == S_RESP) |
                       ((w_state_nxt == S_ACCESS) & w_we_nxt);
`else
  assign w_skip_wait = (DELAYS == 0);
  assign w_ack_nxt   = (w_state_nxt == S_RESP);
`endif

  // Next-state decode of the transfer sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_skip_wait) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        // A master abandoning the cycle cancels the transfer before any
        // BRAM access has been made.
        if (!wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_LAST) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_ACCESS: begin
`ifdef WB_BRAM_CTRL_POSTED_WRITE_EN
        if (r_we) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
`else
        w_state_nxt = S_RESP;
`endif
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, wait counter and latched request fields.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_adr   <= '0;
      r_dat   <= 32'h0;
      r_sel   <= 4'h0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_adr <= wbs_adr_i[N+1:2];
        r_dat <= wbs_dat_i;
        r_sel <= wbs_sel_i;
        r_we  <= wbs_we_i;
        r_cnt <= 8'd0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Registered BRAM strobes and response qualifiers, decoded from next state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_bram_en <= 1'b0;
      r_bram_we <= 4'h0;
      r_ack_arm <= 1'b0;
      r_rd_resp <= 1'b0;
    end else begin
      r_bram_en <= (w_state_nxt == S_ACCESS);
      r_bram_we <= ((w_state_nxt == S_ACCESS) && w_we_nxt) ? w_sel_nxt : 4'h0;
      r_ack_arm <= w_ack_nxt;
      r_rd_resp <= (w_state_nxt == S_RESP) & ~w_we_nxt;
    end
  end

  assign bram_en   = r_bram_en;
  assign bram_we   = r_bram_we;
  assign bram_a    = r_adr;
  assign bram_di   = r_dat;
  assign wbs_ack_o = r_ack_arm & wbs_cyc_i;
  assign wbs_dat_o = (wbs_ack_o && r_rd_resp) ? bram_do : 32'h0;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_bram_ctrl
//
// Directed bench for wb_bram_ctrl. The stimulus process issues Wishbone
// transfers and pushes the expected response (data, latency, BRAM address
// and byte enables) into a queue; a monitor process pops and compares each
// time the DUT acks. A behavioural BRAM model sits on the BRAM port.
// -----------------------------------------------------------------------------
module tb_wb_bram_ctrl;

  localparam int N      = 14;
  localparam int DELAYS = 10;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          wbs_cyc_i = 1'b0;
  logic          wbs_stb_i = 1'b0;
  logic          wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [31:0]   wbs_adr_i = 32'h0;
  logic [31:0]   wbs_dat_i = 32'h0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [N-1:0]  bram_a;
  logic [31:0]   bram_di;
  logic [31:0]   bram_do = 32'h0;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [31:0]  data;
    int           cap;
    int           lat;
    logic [N-1:0] a;
    logic [3:0]   we;
  } exp_t;

  exp_t q[$];

  wb_bram_ctrl #(
    .N(N),
    .DELAYS(DELAYS),
    .BASE_ADDR(32'h3800_0000)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .bram_en(bram_en),
    .bram_we(bram_we),
    .bram_a(bram_a),
    .bram_di(bram_di),
    .bram_do(bram_do)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // BRAM model: read-first, byte writes, output 0 after a disabled cycle.
  logic [31:0] mem [0:(1<<N)-1] = '{default: 32'h0};

  always @(posedge wb_clk_i) begin
    if (bram_en) begin
      bram_do <= mem[bram_a];
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_a][8*b +: 8] <= bram_di[8*b +: 8];
      end
    end else begin
      bram_do <= 32'h0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  function automatic int lat_of(input logic we);
`ifdef WB_BRAM_CTRL_POSTED_WRITE_EN
    return we ? 1 : DELAYS + 2;
`else
    return DELAYS + 2;
`endif
  endfunction

  // Monitor: counts BRAM enables and checks every ack against the scoreboard.
  initial begin
    int           en_cnt;
    logic [N-1:0] en_a;
    logic [3:0]   en_we;
    exp_t         e;
    en_cnt = 0;
    en_a   = '0;
    en_we  = 4'h0;
    forever begin
      @(negedge wb_clk_i);
      if (bram_en) begin
        en_cnt++;
        en_a  = bram_a;
        en_we = bram_we;
      end
      if (wbs_ack_o) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rdata", wbs_dat_o, e.data);
          chk("latency", 32'(cyc_cnt - e.cap + 1), 32'(e.lat));
          chk("en_count", 32'(en_cnt), 32'd1);
          chk("bram_a", 32'(en_a), 32'(e.a));
          chk("bram_we", 32'(en_we), 32'(e.we));
        end
        en_cnt = 0;
      end else begin
        chk("dat_idle_zero", wbs_dat_o, 32'h0);
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  // Capture edge follows; record expectation, wait (bounded) for ack, end cycle.
  task automatic complete(input logic [31:0] exp_data);
    exp_t e;
    logic got;
    @(posedge wb_clk_i);
    #1;
    e.data = exp_data;
    e.cap  = cyc_cnt;
    e.lat  = lat_of(wbs_we_i);
    e.a    = wbs_adr_i[N+1:2];
    e.we   = wbs_we_i ? wbs_sel_i : 4'h0;
    q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    @(posedge wb_clk_i);
    #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp_data);
    drive(we, adr, dat, sel);
    complete(exp_data);
  endtask

  // Watch for n cycles that neither ack nor BRAM enable appears.
  task automatic watch_quiet(input int n, input string nm);
    int errs;
    errs = 0;
    repeat (n) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o || bram_en) errs++;
    end
    chk(nm, 32'(errs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a pending read held on the bus.
    wb_rst_i  = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = 32'h3800_0000;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_a", 32'(bram_a), 32'd0);
    chk("rst_di", bram_di, 32'h0);
    wb_rst_i = 1'b0;
    complete(32'h0000_0000);

    // Full-word write and readback at word 4.
    xfer(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    xfer(1'b0, 32'h3800_0010, 32'h0,         4'h0, 32'hDEAD_BEEF);

    // Single byte-lane merge; address low bits ignored on the readback.
    xfer(1'b1, 32'h3800_0020, 32'h1122_3344, 4'hF,    32'h0);
    xfer(1'b1, 32'h3800_0020, 32'h0000_5A00, 4'b0010, 32'h0);
    xfer(1'b0, 32'h3800_0023, 32'h0,         4'h0,    32'h1122_5A44);

    // Write with no byte lanes: still one BRAM cycle and an ack, no change.
    xfer(1'b1, 32'h3800_0020, 32'hFFFF_FFFF, 4'h0, 32'h0);
    xfer(1'b0, 32'h3800_0020, 32'h0,         4'h0, 32'h1122_5A44);

    // Outside the window: below and just above.
    drive(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    watch_quiet(50, "outside_low");
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    drive(1'b1, 32'h3801_0000, 32'h1234_5678, 4'hF);
    watch_quiet(20, "outside_high");
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;

    // Abort on WAIT cycle 5 (a read when writes are posted, since those
    // never wait).
`ifdef WB_BRAM_CTRL_POSTED_WRITE_EN
    drive(1'b0, 32'h3800_0010, 32'h0, 4'hF);
`else
    drive(1'b1, 32'h3800_0010, 32'hCAFE_F00D, 4'hF);
`endif
    @(posedge wb_clk_i);
    repeat (4) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    watch_quiet(30, "abort_quiet");
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'h0, 32'hDEAD_BEEF);

    // Write immediately followed by a read of the same word.
    xfer(1'b1, 32'h3800_FFFC, 32'hA5A5_0F0F, 4'hF, 32'h0);
    xfer(1'b0, 32'h3800_FFFC, 32'h0,         4'h0, 32'hA5A5_0F0F);

    repeat (5) @(negedge wb_clk_i);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
